// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state type, counter width and parameter defaults for the reset sequencer
package rst_seq_pkg;
  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_REL_BUS,
    ST_REL_IC,
    ST_RUN
  } state_e;
  localparam int CNT_W               = 16;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int HOLD_CYCLES_DEF     = 16;
  localparam int STAGE_GAP_DEF       = 4;
endpackage

// File: rtl/rst_seq_ctrl_rst_sync.sv
// rst_sync: STAGES-deep synchronizer whose async reset loads the asserted-trigger level
module rst_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_ff;
  // shift the async input through the flop chain
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_ff <= {STAGES{RST_VAL}};
    else          r_ff <= {r_ff[STAGES-2:0], d};
  end
  assign q = r_ff[STAGES-1];
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset release (bus, interconnect, peripheral); optional RST_SEQ_SW_REQ_EN adds sw_rst_req
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP   = STAGE_GAP_DEF
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       locked,
  input  logic       ext_reset_in,
  input  logic       aux_reset_in,
`ifdef RST_SEQ_SW_REQ_EN
  input  logic       sw_rst_req,
`endif
  output logic       bus_struct_reset,
  output logic [0:0] interconnect_aresetn,
  output logic [0:0] peripheral_aresetn,
  output logic       seq_done
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic             w_locked_s, w_ext_s, w_aux_s, w_trig;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_bus, r_ic, r_per, r_done;

  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_locked (
    .aclk(aclk), .aresetn(aresetn), .d(locked), .q(w_locked_s));
  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ext (
    .aclk(aclk), .aresetn(aresetn), .d(ext_reset_in), .q(w_ext_s));
  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_aux (
    .aclk(aclk), .aresetn(aresetn), .d(aux_reset_in), .q(w_aux_s));

`ifdef RST_SEQ_SW_REQ_EN
  assign w_trig = !w_locked_s | w_ext_s | !w_aux_s | sw_rst_req;
`else
  assign w_trig = !w_locked_s | w_ext_s | !w_aux_s;
`endif

  // next state and counter; a trigger overrides every terminal condition
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_trig) begin
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_state_nxt = (r_cnt == HOLD_LAST) ? ST_REL_BUS : ST_ASSERT;
          w_cnt_nxt   = (r_cnt == HOLD_LAST) ? '0 : r_cnt + 1'b1;
        end
        ST_REL_BUS: begin
          w_state_nxt = (r_cnt == GAP_LAST) ? ST_REL_IC : ST_REL_BUS;
          w_cnt_nxt   = (r_cnt == GAP_LAST) ? '0 : r_cnt + 1'b1;
        end
        ST_REL_IC: begin
          w_state_nxt = (r_cnt == GAP_LAST) ? ST_RUN : ST_REL_IC;
          w_cnt_nxt   = (r_cnt == GAP_LAST) ? '0 : r_cnt + 1'b1;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // state, counter and outputs registered from the next state so reassertion is simultaneous
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_bus   <= 1'b1;
      r_ic    <= 1'b0;
      r_per   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bus   <= (w_state_nxt == ST_ASSERT);
      r_ic    <= (w_state_nxt == ST_REL_IC) || (w_state_nxt == ST_RUN);
      r_per   <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_RUN);
    end
  end

  assign bus_struct_reset     = r_bus;
  assign interconnect_aresetn = r_ic;
  assign peripheral_aresetn   = r_per;
  assign seq_done             = r_done;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed stimulus checked every cycle against a quiet-time model plus literal edge checks
module tb_rst_seq_ctrl;
  localparam int S    = 2;
  localparam int HOLD = 16;
  localparam int GAP  = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b1;
  logic       locked = 1'b1;
  logic       ext_reset_in = 1'b0;
  logic       aux_reset_in = 1'b1;
  logic       bus_struct_reset;
  logic [0:0] interconnect_aresetn;
  logic [0:0] peripheral_aresetn;
  logic       seq_done;
  int         n_cmp = 0;
  int         n_bad = 0;

  rst_seq_ctrl #(.SYNC_STAGES(S), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .locked(locked),
    .ext_reset_in(ext_reset_in),
    .aux_reset_in(aux_reset_in),
`ifdef RST_SEQ_SW_REQ_EN
    .sw_rst_req(1'b0),
`endif
    .bus_struct_reset(bus_struct_reset),
    .interconnect_aresetn(interconnect_aresetn),
    .peripheral_aresetn(peripheral_aresetn),
    .seq_done(seq_done)
  );

  always #5 aclk = ~aclk;

  // model: inputs delayed S edges; q = consecutive quiet edges; releases at HOLD, HOLD+GAP, HOLD+2*GAP
  logic [S-1:0] m_l = '0, m_e = '1, m_a = '0;
  int           q = 0;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_l = '0; m_e = '1; m_a = '0; q = 0;
    end else begin
      if (!m_l[S-1] || m_e[S-1] || !m_a[S-1]) q = 0;
      else if (q < HOLD + 2*GAP) q = q + 1;
      m_l = {m_l[S-2:0], locked};
      m_e = {m_e[S-2:0], ext_reset_in};
      m_a = {m_a[S-2:0], aux_reset_in};
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge aclk) begin
    chk("model_bus", bus_struct_reset, q < HOLD);
    chk("model_ic",  interconnect_aresetn[0], q >= HOLD + GAP);
    chk("model_per", peripheral_aresetn[0], q >= HOLD + 2*GAP);
    chk("model_done", seq_done, q >= HOLD + 2*GAP);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_sig(input int which, input int budget);
    int k;
    k = 0;
    while (!(which == 0 ? interconnect_aresetn[0] === 1'b1 : bus_struct_reset === 1'b0) && k < budget) begin
      step();
      k++;
    end
    chk("wait_bound", k < budget, 1'b1);
  endtask

  initial begin
    #3 aresetn = 1'b0;
    #1;
    chk("rst_bus", bus_struct_reset, 1'b1);
    chk("rst_ic", interconnect_aresetn[0], 1'b0);
    chk("rst_per", peripheral_aresetn[0], 1'b0);
    chk("rst_done", seq_done, 1'b0);
    run(3);
    @(negedge aclk);
    #1 aresetn = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      step();
      if (e == 17) chk("cold_bus17", bus_struct_reset, 1'b1);
      if (e == 18) chk("cold_bus18", bus_struct_reset, 1'b0);
      if (e == 21) chk("cold_ic21", interconnect_aresetn[0], 1'b0);
      if (e == 22) chk("cold_ic22", interconnect_aresetn[0], 1'b1);
      if (e == 25) chk("cold_per25", peripheral_aresetn[0], 1'b0);
      if (e == 26) chk("cold_per26", peripheral_aresetn[0], 1'b1);
      if (e == 26) chk("cold_done26", seq_done, 1'b1);
    end
    run(3);
    locked = 1'b0;
    step();
    locked = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 2) chk("lock_bus", bus_struct_reset, 1'b1);
      if (k == 2) chk("lock_per", peripheral_aresetn[0], 1'b0);
      if (k == 25) chk("lock_per25", peripheral_aresetn[0], 1'b0);
      if (k == 26) chk("lock_per26", peripheral_aresetn[0], 1'b1);
    end
    ext_reset_in = 1'b1;
    run(4);
    ext_reset_in = 1'b0;
    wait_sig(0, 40);
    ext_reset_in = 1'b1;
    step();
    ext_reset_in = 1'b0;
    run(2);
    chk("ext_ic", interconnect_aresetn[0], 1'b0);
    chk("ext_bus", bus_struct_reset, 1'b1);
    run(30);
    chk("ext_done", seq_done, 1'b1);
    ext_reset_in = 1'b1;
    run(5);
    ext_reset_in = 1'b0;
    run(15);
    ext_reset_in = 1'b1;
    run(3);
    chk("hold15_bus", bus_struct_reset, 1'b1);
    run(2);
    chk("hold15_bus2", bus_struct_reset, 1'b1);
    ext_reset_in = 1'b0;
    wait_sig(1, 40);
    step();
    #2 aresetn = 1'b0;
    #1;
    chk("async_bus", bus_struct_reset, 1'b1);
    chk("async_ic", interconnect_aresetn[0], 1'b0);
    chk("async_per", peripheral_aresetn[0], 1'b0);
    chk("async_done", seq_done, 1'b0);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    run(30);
    chk("async_recover", seq_done, 1'b1);
    aux_reset_in = 1'b0;
    step();
    aux_reset_in = 1'b1;
    run(3);
    chk("aux_per", peripheral_aresetn[0], 1'b0);
    run(30);
    chk("aux_done", seq_done, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit reached at %0t", $time);
    $fatal(1);
  end
endmodule
